// File: rtl/instr_mem_pipe.sv
// Loadable, synchronously read instruction memory with wait states and a valid/ready fetch handshake.
// Define IMEM_PERF_CNT_EN to build the fetch/stall performance counters.
module instr_mem_pipe #(
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       DEPTH       = 1024,
    parameter int unsigned       ADDR_W      = 32,
    parameter int unsigned       WAIT_STATES = 0,
    parameter logic [DATA_W-1:0] NOP_WORD    = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic                     flush,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [DATA_W-1:0]        resp_instr,
    output logic [ADDR_W-1:0]        resp_addr,
    output logic                     resp_fault_align,
    output logic                     resp_fault_range,
    input  logic                     ld_en,
    input  logic [$clog2(DEPTH)-1:0] ld_addr,
    input  logic [DATA_W-1:0]        ld_data,
    output logic [31:0]              perf_fetch_cnt,
    output logic [31:0]              perf_stall_cnt
);

    localparam int unsigned    MEM_AW    = $clog2(DEPTH);
    localparam int unsigned    IDX_W     = ADDR_W - 2;
    localparam int unsigned    CNT_W     = 4;
    localparam bit             HAS_WAIT  = (WAIT_STATES > 0);
    localparam logic [CNT_W-1:0] WAIT_LAST = HAS_WAIT ? CNT_W'(WAIT_STATES - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic               accept;
    logic [IDX_W-1:0]   idx;
    logic               fault_align;
    logic               fault_range;
    logic               ld_ok;
    logic [DATA_W-1:0]  rd_word;

    // Power-up content is the NOP word; rst never touches the array.
    logic [DATA_W-1:0]  mem [DEPTH] = '{default: NOP_WORD};

    assign idx         = req_addr[ADDR_W-1:2];
    assign fault_align = (req_addr[1:0] != 2'b00);
    assign fault_range = (idx >= IDX_W'(DEPTH));
    assign rd_word     = mem[idx[MEM_AW-1:0]];
    assign resp_valid  = (state == S_RESP);

    // A power-of-two depth makes every loader index legal.
    generate
        if ((1 << MEM_AW) == DEPTH) begin : g_ld_full
            assign ld_ok = 1'b1;
        end else begin : g_ld_part
            assign ld_ok = (32'(ld_addr) < DEPTH);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (ld_en && ld_ok) begin
            mem[ld_addr] <= ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        req_ready  = 1'b0;
        case (state)
            S_IDLE: req_ready = 1'b1;
            S_WAIT: begin
                cnt_next = cnt + CNT_W'(1);
                if (cnt == WAIT_LAST) begin
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                req_ready = resp_ready;
                if (resp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
        // Flush (and reset) kill the in-flight request and block acceptance this cycle.
        if (flush || rst) begin
            req_ready  = 1'b0;
            state_next = S_IDLE;
            cnt_next   = '0;
        end
        accept = req_valid && req_ready;
        if (accept) begin
            state_next = HAS_WAIT ? S_WAIT : S_RESP;
            cnt_next   = '0;
        end
    end

    // Response payload is captured at the acceptance edge and held until the next acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_instr       <= '0;
            resp_addr        <= '0;
            resp_fault_align <= 1'b0;
            resp_fault_range <= 1'b0;
        end else if (accept) begin
            resp_instr       <= (fault_align || fault_range) ? NOP_WORD : rd_word;
            resp_addr        <= req_addr;
            resp_fault_align <= fault_align;
            resp_fault_range <= fault_range;
        end
    end

`ifdef IMEM_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (accept) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (resp_valid && !resp_ready) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`else
    assign perf_fetch_cnt = 32'd0;
    assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: doc/instr_mem_pipe.md
Name: instr_mem_pipe

Overview:
Parametrised, synchronously read instruction memory for the fetch stage of the lab processor. It replaces the combinational, hard-coded instruction ROM with a loadable array. The array has configurable wait states, which model a slow SRAM. A valid/ready request/response handshake connects it to the fetch stage, with a flush for branch redirects and fault flags for bad fetch addresses. A loader port fills the array before or between runs.

Parameters:
DATA_W, 32, instruction width in bits
DEPTH, 1024, number of instruction words
ADDR_W, 32, byte address width from PC
WAIT_STATES, 0, extra cycles of read latency (0..15)
NOP_WORD, 32'h0000_0000, word returned on fault; also the initial array content

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
req_valid  in  1  fetch request
req_ready  out  1  request accepted when req_valid & req_ready
req_addr  in  ADDR_W  byte address (PC)
flush  in  1  drop the outstanding request/response (branch taken)
resp_valid  out  1  response available
resp_ready  in  1  fetch stage consumes response
resp_instr  out  DATA_W  instruction word
resp_addr  out  ADDR_W  byte address of this response
resp_fault_align  out  1  req_addr[1:0] != 0
resp_fault_range  out  1  word index >= DEPTH
ld_en  in  1  loader write strobe
ld_addr  in  $clog2(DEPTH)  word index to write
ld_data  in  DATA_W  word to write
perf_fetch_cnt  out  32  accepted requests (optional feature)
perf_stall_cnt  out  32  cycles with resp_valid & !resp_ready (optional feature)

Behaviour:
- Word index is req_addr[ADDR_W-1:2].
- Array contents are not affected by rst.
- Simulation initial content: every word = NOP_WORD.
- Reset values (next edge with rst=1):
  - state=IDLE, resp_valid=0, resp_instr=0, resp_addr=0, both fault flags 0.
  - wait counter 0; perf counters 0.
- States:
  - IDLE: req_ready=1. On accept: go to WAIT if WAIT_STATES>0, else to RESP.
  - WAIT: req_ready=0. Counter counts WAIT_STATES cycles, then goes to RESP.
  - RESP: resp_valid=1.
    - If resp_ready=1, req_ready=1: a new request can be accepted the same cycle.
    - resp_ready & !req_valid: go to IDLE.
    - resp_ready & req_valid: accept the new request; go to WAIT, or stay in RESP with the new data.
    - !resp_ready: hold; resp_* outputs stay stable.
- Latency: resp_valid rises WAIT_STATES+1 cycles after the acceptance edge.
- Throughput with WAIT_STATES=0: one instruction per cycle.
- Read data is the array content at the acceptance edge. A same-edge ld_en write to the same index is not seen; the old word is returned.
- Faults:
  - Misaligned address: resp_instr=NOP_WORD, resp_fault_align=1.
  - Index >= DEPTH: resp_instr=NOP_WORD, resp_fault_range=1.
  - Both flags may assert together.
  - A faulted response still takes the full latency.
- Loader: ld_en writes ld_data to mem[ld_addr] on the edge.
  - ld_addr >= DEPTH is ignored.
  - Writes are allowed in any state.
- Flush (synchronous):
  - Next state is IDLE, resp_valid=0, wait counter cleared.
  - req_ready=0 during the flush cycle, so no acceptance that cycle.
  - A response presented in the flush cycle is discarded even if resp_ready=1; the fetch stage ignores it.
- rst overrides flush and all other inputs. rst mid-WAIT or mid-RESP drops everything; the next cycle is IDLE.

Optional Feature:
IMEM_PERF_CNT_EN
- Defined:
  - perf_fetch_cnt increments on each accepted request.
  - perf_stall_cnt increments each cycle with resp_valid=1 & resp_ready=0.
  - Both counters wrap at 2^32, clear on rst, and are not cleared by flush.
- Not defined: both ports are driven constant 0 and no counter logic is present.

Test Plan:
- Load ld_addr=1 -> 0x8001_0001, WAIT_STATES=2, fetch req_addr=0x4 -> resp_valid exactly 3 cycles after accept, resp_instr=0x8001_0001, resp_addr=0x4, flags 0.
- req_addr=0x6 -> resp_instr=NOP_WORD, resp_fault_align=1. req_addr=0x1000 with DEPTH=1024 -> resp_fault_range=1, instr=NOP_WORD.
- WAIT_STATES=0, req_valid held high, resp_ready=1, addresses 0,4,8,12 -> four consecutive responses on four consecutive cycles, in order.
- Hold resp_ready=0 for 5 cycles in RESP -> resp_* stable, req_ready=0; with IMEM_PERF_CNT_EN, perf_stall_cnt=5.
- Flush asserted in the 2nd WAIT cycle (WAIT_STATES=3) -> no resp_valid for that request; IDLE next cycle; the next request completes normally.
- ld_en writing index 2 on the same edge a fetch of 0x8 is accepted -> old word returned; a re-fetch returns the new word. rst in RESP -> resp_valid=0 next cycle.
